// File: rtl/apb_rambus_bridge_if.sv
// APB3 + RamBus signal bundle for apb_rambus_bridge.
// slave modport: bridge view; master modport: APB master / RamBus target view.
interface apb_rambus_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  PSel;
    logic                  PEnable;
    logic                  PWrite;
    logic [31:0]           PAddr;
    logic [DATA_WIDTH-1:0] PWData;
    logic [DATA_WIDTH-1:0] PRData;
    logic                  PReady;
    logic                  PSlvErr;
    logic [ADDR_WIDTH-1:0] RamBusAddress;
    logic [DATA_WIDTH-1:0] RamBusDataIn;
    logic                  RamBusnCs;
    logic                  RamBusWrnRd;
    logic                  RamBusLatch;
    logic [DATA_WIDTH-1:0] RamBusDataOut;
    logic                  RamBusAck;

    modport slave (
        input  PSel, PEnable, PWrite, PAddr, PWData,
        output PRData, PReady, PSlvErr,
        output RamBusAddress, RamBusDataIn, RamBusnCs, RamBusWrnRd, RamBusLatch,
        input  RamBusDataOut, RamBusAck
    );

    modport master (
        output PSel, PEnable, PWrite, PAddr, PWData,
        input  PRData, PReady, PSlvErr,
        input  RamBusAddress, RamBusDataIn, RamBusnCs, RamBusWrnRd, RamBusLatch,
        output RamBusDataOut, RamBusAck
    );
endinterface

// File: rtl/apb_rambus_bridge.sv
// APB3 slave turning one APB transfer into one RamBus access (DM main-ports register file).
// All outputs are registered. Optional WAIT-state timeout is enabled by APB_RAMBUS_TIMEOUT_EN;
// without it the bridge waits for RamBusAck indefinitely and PSlvErr is tied low.
module apb_rambus_bridge #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                rst,
    apb_rambus_bridge_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] prData;
    logic                  pReady;
    logic [ADDR_WIDTH-1:0] rbAddr;
    logic [DATA_WIDTH-1:0] rbDataIn;
    logic                  rbnCs;
    logic                  rbWrnRd;
    logic                  rbLatch;

`ifdef APB_RAMBUS_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic        slvErr;
    logic [15:0] waitCnt;
`else
    localparam int unsigned unusedTimeoutCycles = TIMEOUT_CYCLES;
`endif

    // Upper APB address bits are decoded upstream and not forwarded.
    logic unusedAddrBits;
    assign unusedAddrBits = ^bus.PAddr[31:ADDR_WIDTH];

    // Transfer FSM; every RamBus/APB output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            prData   <= '0;
            pReady   <= 1'b0;
            rbAddr   <= '0;
            rbDataIn <= '0;
            rbnCs    <= 1'b1;
            rbWrnRd  <= 1'b0;
            rbLatch  <= 1'b0;
`ifdef APB_RAMBUS_TIMEOUT_EN
            slvErr   <= 1'b0;
            waitCnt  <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    // Capture on the APB setup phase so the access starts one cycle later.
                    if (bus.PSel && !bus.PEnable) begin
                        rbAddr   <= bus.PAddr[ADDR_WIDTH-1:0];
                        rbDataIn <= bus.PWData;
                        rbWrnRd  <= bus.PWrite;
                        rbnCs    <= 1'b0;
                        rbLatch  <= 1'b1;
                        state    <= StReq;
                    end
                end
                StReq: begin
                    rbLatch <= 1'b0;
`ifdef APB_RAMBUS_TIMEOUT_EN
                    waitCnt <= '0;
`endif
                    if (!bus.PSel) begin
                        rbnCs <= 1'b1;
                        state <= StIdle;
                    end else begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (!bus.PSel) begin
                        // Master abandoned the transfer: drop the access, no completion.
                        rbnCs <= 1'b1;
                        state <= StIdle;
                    end else if (bus.RamBusAck) begin
                        if (!rbWrnRd) prData <= bus.RamBusDataOut;
`ifdef APB_RAMBUS_TIMEOUT_EN
                        slvErr <= 1'b0;
`endif
                        pReady <= 1'b1;
                        rbnCs  <= 1'b1;
                        state  <= StResp;
                    end else begin
`ifdef APB_RAMBUS_TIMEOUT_EN
                        // Ack has priority; only a cycle without ack can time out.
                        if (waitCnt == TimeoutLast) begin
                            if (!rbWrnRd) prData <= '0;
                            slvErr <= 1'b1;
                            pReady <= 1'b1;
                            rbnCs  <= 1'b1;
                            state  <= StResp;
                        end else begin
                            waitCnt <= waitCnt + 16'd1;
                        end
`endif
                    end
                end
                StResp: begin
                    pReady <= 1'b0;
`ifdef APB_RAMBUS_TIMEOUT_EN
                    slvErr <= 1'b0;
`endif
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.PRData        = prData;
    assign bus.PReady        = pReady;
    assign bus.RamBusAddress = rbAddr;
    assign bus.RamBusDataIn  = rbDataIn;
    assign bus.RamBusnCs     = rbnCs;
    assign bus.RamBusWrnRd   = rbWrnRd;
    assign bus.RamBusLatch   = rbLatch;
`ifdef APB_RAMBUS_TIMEOUT_EN
    assign bus.PSlvErr       = slvErr;
`else
    assign bus.PSlvErr       = 1'b0;
`endif
endmodule

// File: tb/tb_apb_rambus_bridge.sv
// Scoreboard bench for apb_rambus_bridge: the APB driver pushes expected {PRData, PSlvErr}
// per transfer, a monitor pops on every PReady; a RamBus responder answers each latch strobe.
module tb_apb_rambus_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;

    apb_rambus_bridge_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

    apb_rambus_bridge #(
        .ADDR_WIDTH(14),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] expQ[$];
    int          readyTimes[$];
    int          cycle    = 0;
    int          latchCnt = 0;
    int          ackDelay = 0;  // 0 = responder never acks
    logic [31:0] ackData  = '0;
    logic [31:0] expRd    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_prdata"}, bus.PRData, 32'h0);
        chk({tag, "_pready"}, {31'b0, bus.PReady}, 32'h0);
        chk({tag, "_pslverr"}, {31'b0, bus.PSlvErr}, 32'h0);
        chk({tag, "_addr"}, {18'b0, bus.RamBusAddress}, 32'h0);
        chk({tag, "_datain"}, bus.RamBusDataIn, 32'h0);
        chk({tag, "_ncs"}, {31'b0, bus.RamBusnCs}, 32'h1);
        chk({tag, "_wrnrd"}, {31'b0, bus.RamBusWrnRd}, 32'h0);
        chk({tag, "_latch"}, {31'b0, bus.RamBusLatch}, 32'h0);
    endtask

    // Monitor: sample just after each rising edge; every PReady must match a queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (bus.RamBusLatch === 1'b1) latchCnt++;
            if (bus.PReady === 1'b1) begin
                readyTimes.push_back(cycle);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pready actual=1 expected=0 cycle=%0d", cycle);
                end else begin
                    logic [32:0] e;
                    e = expQ.pop_front();
                    chk("resp_prdata", bus.PRData, e[32:1]);
                    chk("resp_pslverr", {31'b0, bus.PSlvErr}, {31'b0, e[0]});
                end
            end
        end
    end

    // RamBus responder: after seeing the latch strobe, ack for one cycle ackDelay cycles later.
    initial begin
        bus.RamBusAck     = 1'b0;
        bus.RamBusDataOut = '0;
        forever begin
            @(negedge clk);
            if (bus.RamBusLatch === 1'b1 && ackDelay != 0) begin
                int d;
                d = ackDelay;
                repeat (d) @(negedge clk);
                bus.RamBusAck     = 1'b1;
                bus.RamBusDataOut = ackData;
                @(negedge clk);
                bus.RamBusAck     = 1'b0;
            end
        end
    end

    // One full APB transfer; returns at the negedge of the PReady cycle with PSel still high.
    task automatic apbXfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input logic [31:0] rdVal, input logic expErr,
                           input int expLat);
        int   lat;
        logic bad;
        ackDelay = delay;
        ackData  = rdVal;
        if (expErr && !wr) expRd = 32'h0;
        else if (!wr) expRd = rdVal;
        expQ.push_back({expRd, expErr});
        @(negedge clk);
        bus.PSel    = 1'b1;
        bus.PEnable = 1'b0;
        bus.PWrite  = wr;
        bus.PAddr   = addr;
        bus.PWData  = wdata;
        @(negedge clk);
        bus.PEnable = 1'b1;
        chk("req_latch", {31'b0, bus.RamBusLatch}, 32'h1);
        chk("req_ncs", {31'b0, bus.RamBusnCs}, 32'h0);
        chk("req_addr", {18'b0, bus.RamBusAddress}, {18'b0, addr[13:0]});
        chk("req_datain", bus.RamBusDataIn, wdata);
        chk("req_wrnrd", {31'b0, bus.RamBusWrnRd}, {31'b0, wr});
        lat = 1;
        bad = 1'b0;
        while (bus.PReady !== 1'b1 && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (bus.PReady !== 1'b1 && (bus.RamBusnCs !== 1'b0 || bus.RamBusLatch !== 1'b0))
                bad = 1'b1;
        end
        chk("latency", lat, expLat);
        chk("wait_cs_held", {31'b0, bad}, 32'h0);
        if (bus.PReady === 1'b1) begin
            chk("resp_ncs", {31'b0, bus.RamBusnCs}, 32'h1);
        end else begin
            bus.PSel    = 1'b0;
            bus.PEnable = 1'b0;
        end
    endtask

    task automatic apbIdle();
        @(negedge clk);
        bus.PSel    = 1'b0;
        bus.PEnable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb;
        int tb0;
        int rdy;
        bus.PSel    = 1'b0;
        bus.PEnable = 1'b0;
        bus.PWrite  = 1'b0;
        bus.PAddr   = '0;
        bus.PWData  = '0;
        repeat (3) @(negedge clk);
        chkReset("rst");
        rst = 1'b0;
        @(negedge clk);

        // Write, ack in first WAIT cycle.
        apbXfer(1'b1, 32'h0000_1234, 32'hCAFE_F00D, 1, 32'h0, 1'b0, 3);
        apbIdle();
        chk("wr_addr_hold", {18'b0, bus.RamBusAddress}, 32'h0000_1234);

        // Read, ack delayed 5 cycles.
        apbXfer(1'b0, 32'h0000_2000, 32'h0, 5, 32'hA5A5_5A5A, 1'b0, 7);
        apbIdle();

        // Back-to-back read, write, read.
        lb  = latchCnt;
        tb0 = readyTimes.size();
        apbXfer(1'b0, 32'h0000_0010, 32'h0, 1, 32'h1111_1111, 1'b0, 3);
        apbXfer(1'b1, 32'h0000_0020, 32'h2222_2222, 1, 32'h0, 1'b0, 3);
        apbXfer(1'b0, 32'h0000_0030, 32'h0, 1, 32'h3333_3333, 1'b0, 3);
        apbIdle();
        @(negedge clk);
        chk("b2b_latches", latchCnt - lb, 3);
        chk("b2b_readys", readyTimes.size() - tb0, 3);
        if (readyTimes.size() >= tb0 + 3) begin
            chk("b2b_gap1", readyTimes[tb0+1] - readyTimes[tb0], 4);
            chk("b2b_gap2", readyTimes[tb0+2] - readyTimes[tb0+1], 4);
        end

        // Abort: PSel dropped in WAIT.
        ackDelay = 0;
        @(negedge clk);
        bus.PSel = 1'b1; bus.PEnable = 1'b0; bus.PWrite = 1'b0; bus.PAddr = 32'h0000_0ABC;
        @(negedge clk);
        bus.PEnable = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_wait_ncs", {31'b0, bus.RamBusnCs}, 32'h0);
        bus.PSel = 1'b0; bus.PEnable = 1'b0;
        @(negedge clk);
        chk("abort_ncs", {31'b0, bus.RamBusnCs}, 32'h1);
        chk("abort_pready", {31'b0, bus.PReady}, 32'h0);
        chk("abort_prdata", bus.PRData, 32'h3333_3333);
        apbXfer(1'b0, 32'h0000_0040, 32'h0, 2, 32'h4444_4444, 1'b0, 4);
        apbIdle();

        // Reset during WAIT; the late ack must be ignored.
        ackDelay = 4;
        ackData  = 32'h7777_7777;
        @(negedge clk);
        bus.PSel = 1'b1; bus.PEnable = 1'b0; bus.PWrite = 1'b1; bus.PAddr = 32'h0000_0BCD;
        bus.PWData = 32'h1234_5678;
        @(negedge clk);
        bus.PEnable = 1'b1;
        @(negedge clk);
        rst = 1'b1; bus.PSel = 1'b0; bus.PEnable = 1'b0;
        @(negedge clk);
        chkReset("midrst");
        rst   = 1'b0;
        expRd = 32'h0;
        repeat (6) @(negedge clk);
        chk("late_ack_prdata", bus.PRData, 32'h0);
        chk("late_ack_ncs", {31'b0, bus.RamBusnCs}, 32'h1);

        apbXfer(1'b0, 32'h0000_0050, 32'h0, 1, 32'h5555_5555, 1'b0, 3);
        apbIdle();
        // Ack on the eighth WAIT cycle (coincides with the timeout limit when enabled).
        apbXfer(1'b0, 32'h0000_0060, 32'h0, 8, 32'h6666_6666, 1'b0, 10);
        apbIdle();

`ifdef APB_RAMBUS_TIMEOUT_EN
        apbXfer(1'b0, 32'h0000_0070, 32'h0, 0, 32'h0, 1'b1, 10);
        apbIdle();
`else
        ackDelay = 0;
        @(negedge clk);
        bus.PSel = 1'b1; bus.PEnable = 1'b0; bus.PWrite = 1'b0; bus.PAddr = 32'h0000_0070;
        @(negedge clk);
        bus.PEnable = 1'b1;
        rdy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.PReady === 1'b1) rdy++;
        end
        chk("noto_pready_count", rdy, 0);
        chk("noto_ncs_held", {31'b0, bus.RamBusnCs}, 32'h0);
        chk("noto_prdata", bus.PRData, 32'h6666_6666);
        bus.PSel = 1'b0; bus.PEnable = 1'b0;
        @(negedge clk);
        chk("noto_abort_ncs", {31'b0, bus.RamBusnCs}, 32'h1);
`endif

        repeat (5) @(negedge clk);
        chk("pending_expectations", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
